scoreboard: RTL and testbench
=============================

# scoreboard

Per-register in-flight write tracker that generates the decode-stage stall for the RV64 pipeline. It sits beside the decode stage. Each architectural register has a saturating counter: issue from ID into EX increments it, and writeback retire or flush-kill decrements it. Decode stalls while any source register it reads, or its destination counter, is unresolved.

## Interface
Parameters:
- NREG, 32: number of architectural registers; register 0 is never tracked.
- CNT_W, 2: counter width; at most 2^CNT_W−1 in-flight writes per register.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  **synchronous, active-low reset**; sampled only on the clk rising edge.
- freeze  in  1  pipeline frozen (Iwait | Dwait); no issue is counted while high.
- dec_valid  in  1  decode holds a real instruction (not a bubble).
- dec_ra1, dec_ra2  in  5  source register indices.
- dec_use1, dec_use2  in  1  the instruction actually reads ra1 / ra2.
- dec_dst  in  5  destination register index.
- dec_wen  in  1  the instruction writes dec_dst.
- wb_valid  in  1  an instruction retires in writeback this cycle.
- wb_dst  in  5  its destination register.
- wb_wen  in  1  it writes a register.
- kill_valid  in  1  one flushed in-flight instruction is cancelled this cycle.
- kill_dst  in  5  destination of the cancelled instruction.
- stall  out  1  hold IF/ID and insert a bubble into ID/EX.
- issue  out  1  the decode instruction is accepted this cycle.
- busy_vec  out  NREG  busy_vec[r] = (cnt[r] != 0), registered view.
- err  out  1  sticky underflow error.

## Operation
- Counters: cnt[r] is CNT_W bits wide; cnt[0] is hardwired to 0.
- Lookup: busy(r) = (r != 0) && (cnt[r] != 0).
- Stall condition: stall = dec_valid && ((dec_use1 && busy(ra1)) || (dec_use2 && busy(ra2)) || (dec_wen && dec_dst != 0 && cnt[dec_dst] == MAX)), where MAX = 2^CNT_W−1.
- Issue: issue = dec_valid && !stall && !freeze.
- Per-register update each cycle: next = cnt[r] + inc − dec_wb − dec_kill.
  - inc = issue && dec_wen && dec_dst == r.
  - dec_wb = wb_valid && wb_wen && wb_dst == r.
  - dec_kill = kill_valid && kill_dst == r.
- Simultaneous events: increment and decrement on the same register net out. Retire plus kill on the same register subtracts 2. All three together subtract 1.
- Underflow: if the computed next value would be negative, the counter holds 0 and err is set. err stays set until reset.
- Overflow cannot occur, because the MAX check already stalls issue.
- Register 0: writes to or reads of register 0 are ignored in every path.
- freeze: blocks increments only. wb_valid and kill_valid are counted regardless; the caller qualifies them.

## Timing
- stall and issue are combinational from current inputs and registered counters. There are no flops on the decode path.
- Counter updates become visible in stall and busy_vec on the cycle after the event.
- Back-to-back: a producer issued in cycle N stalls a dependent consumer from cycle N+1 until the cycle after its retire (or kill) cycle. The SB_WB_BYPASS_EN macro shortens this by one cycle.
- Reset, when reset=0 at a rising edge: all cnt cleared to 0 and err cleared. Outputs after reset: busy_vec = 0, err = 0, stall = 0 while dec_valid = 0.
- Reset asserted mid-operation discards all in-flight state. Any retire or kill arriving afterwards for that state is an underflow and sets err. The integrator must flush the pipeline together with reset.

## Configuration
- SB_WB_BYPASS_EN defined:
  - busy(r) is also false when cnt[r] == 1 and a write to r retires in the same cycle (wb_valid && wb_wen && wb_dst == r).
  - This lets a consumer issue in the writeback cycle, relying on write-first register-file read.
  - busy_vec is unaffected.
- SB_WB_BYPASS_EN undefined:
  - busy uses the registered counter only.
  - The consumer issues one cycle after retire.

## Test plan
- Reset then idle: hold reset=0 for 2 cycles, release → busy_vec=0, err=0, stall=0. With dec_valid=1 reading x0, x0 → issue=1.
- RAW on x5:
  - Cycle 0: issue ADD x5 → cnt[5]=1 in cycle 1.
  - Cycle 1: consumer reads x5 → stall=1.
  - Cycle 3: retire x5 → stall=0 from cycle 4, or in cycle 3 with SB_WB_BYPASS_EN.
- Saturation (CNT_W=2): three writes to x7 with no retire → cnt[7]=3; a fourth write to x7 → stall=1, issue=0. One retire → the next cycle issues.
- Simultaneous issue and retire on x9 with cnt[9]=1 → cnt[9] stays 1. Retire plus kill on x9 with cnt[9]=2 → cnt[9]=0.
- Freeze: freeze=1 with a valid non-stalled write to x3 → issue=0 and cnt[3] unchanged. A concurrent wb retire of x4 (cnt 1) → cnt[4]=0.
- Underflow: retire x12 with cnt[12]=0 → cnt[12]=0 and err=1, sticky across 10 idle cycles until reset.

Source files
------------

// File: rtl/scoreboard.sv
// Per-register in-flight write counters that produce the decode stall.
// Define SB_WB_BYPASS_EN to release consumers in the retire cycle.
module scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            freeze,
    input  logic            dec_valid,
    input  logic [4:0]      dec_ra1,
    input  logic [4:0]      dec_ra2,
    input  logic            dec_use1,
    input  logic            dec_use2,
    input  logic [4:0]      dec_dst,
    input  logic            dec_wen,
    input  logic            wb_valid,
    input  logic [4:0]      wb_dst,
    input  logic            wb_wen,
    input  logic            kill_valid,
    input  logic [4:0]      kill_dst,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] busy_vec,
    output logic            err
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             err_q;
    logic             err_d;
    logic [NREG-1:0]  uf;
    logic             wb_hit;
    logic             dst_full;

    assign wb_hit = wb_valid && wb_wen;

    function automatic logic busy_f(input logic [4:0] r);
        logic hit;
        hit = (r != 5'd0) && (cnt_q[r] != '0);
`ifdef SB_WB_BYPASS_EN
        // Write-first regfile lets the last pending write forward now.
        if (cnt_q[r] == CNT_W'(1) && wb_hit && wb_dst == r) begin
            hit = 1'b0;
        end
`endif
        return hit;
    endfunction

    assign dst_full = dec_wen && (dec_dst != 5'd0) && (cnt_q[dec_dst] == MAX);

    assign stall = dec_valid && ((dec_use1 && busy_f(dec_ra1)) ||
                                 (dec_use2 && busy_f(dec_ra2)) ||
                                 dst_full);

    assign issue = dec_valid && !stall && !freeze;

    assign uf[0]       = 1'b0;
    assign cnt_d[0]    = '0;
    assign busy_vec[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        logic           inc;
        logic           dwb;
        logic           dkl;
        logic [CNT_W:0] up;
        logic [CNT_W:0] dn;

        assign inc = issue && dec_wen && (dec_dst == 5'(g));
        assign dwb = wb_hit && (wb_dst == 5'(g));
        assign dkl = kill_valid && (kill_dst == 5'(g));
        assign up  = {1'b0, cnt_q[g]} + (CNT_W+1)'(inc);
        assign dn  = (CNT_W+1)'(dwb) + (CNT_W+1)'(dkl);

        assign uf[g]       = up < dn;
        assign cnt_d[g]    = uf[g] ? '0 : CNT_W'(up - dn);
        assign busy_vec[g] = cnt_q[g] != '0;
    end

    assign err_d = err_q | (|uf);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the decode scoreboard.
// Expectations follow SB_WB_BYPASS_EN when the bench is built with it.
module tb_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic        dec_valid;
    logic [4:0]  dec_ra1, dec_ra2, dec_dst;
    logic        dec_use1, dec_use2, dec_wen;
    logic        wb_valid, wb_wen, kill_valid;
    logic [4:0]  wb_dst, kill_dst;
    logic        stall, issue, err;
    logic [31:0] busy_vec;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef SB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .dec_valid (dec_valid),
        .dec_ra1   (dec_ra1),
        .dec_ra2   (dec_ra2),
        .dec_use1  (dec_use1),
        .dec_use2  (dec_use2),
        .dec_dst   (dec_dst),
        .dec_wen   (dec_wen),
        .wb_valid  (wb_valid),
        .wb_dst    (wb_dst),
        .wb_wen    (wb_wen),
        .kill_valid(kill_valid),
        .kill_dst  (kill_dst),
        .stall     (stall),
        .issue     (issue),
        .busy_vec  (busy_vec),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        freeze = 0; dec_valid = 0;
        dec_ra1 = 0; dec_ra2 = 0; dec_use1 = 0; dec_use2 = 0;
        dec_dst = 0; dec_wen = 0;
        wb_valid = 0; wb_dst = 0; wb_wen = 0;
        kill_valid = 0; kill_dst = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    task automatic wr(input logic [4:0] d);
        dec_valid = 1; dec_wen = 1; dec_dst = d;
    endtask

    task automatic rd1(input logic [4:0] r);
        dec_valid = 1; dec_use1 = 1; dec_ra1 = r;
    endtask

    task automatic ret(input logic [4:0] d);
        wb_valid = 1; wb_wen = 1; wb_dst = d;
    endtask

    initial begin
        idle();
        reset = 1;
        do_reset();

        // reset and idle
        probe();
        chk("rst_busy", busy_vec, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        step();
        dec_valid = 1; dec_use1 = 1; dec_use2 = 1;
        probe();
        chk("x0_issue", issue, 1);
        chk("x0_stall", stall, 0);
        step(); idle();

        // RAW on x5
        wr(5);
        probe();
        chk("raw_prod_issue", issue, 1);
        step(); idle();
        rd1(5);
        probe();
        chk("raw_c1_stall", stall, 1);
        chk("raw_c1_issue", issue, 0);
        chk("raw_c1_busy", busy_vec[5], 1);
        step(); idle();
        dec_valid = 1; dec_use2 = 1; dec_ra2 = 5; dec_ra1 = 5;
        probe();
        chk("raw_c2_ra2_stall", stall, 1);
        step(); idle();
        rd1(5); ret(5);
        probe();
        chk("raw_c3_stall", stall, !BYP);
        chk("raw_c3_busy", busy_vec[5], 1);
        step(); idle();
        rd1(5);
        probe();
        chk("raw_c4_stall", stall, 0);
        chk("raw_c4_issue", issue, 1);
        chk("raw_c4_busy", busy_vec[5], 0);
        step(); idle();
        dec_valid = 1; dec_ra1 = 5; dec_ra2 = 5;
        probe();
        chk("nouse_stall", stall, 0);
        step();

        // saturation on x7
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr(7);
            probe();
            chk($sformatf("sat_w%0d_issue", i), issue, 1);
            step();
        end
        wr(7);
        probe();
        chk("sat_cnt3", dut.cnt_q[7], 3);
        chk("sat_stall", stall, 1);
        chk("sat_issue", issue, 0);
        step();
        ret(7);
        probe();
        chk("sat_ret_stall", stall, 1);
        step(); idle();
        wr(7);
        probe();
        chk("sat_after_issue", issue, 1);
        step(); idle();
        probe();
        chk("sat_refill", dut.cnt_q[7], 3);

        // simultaneous events on x9
        do_reset();
        wr(9);
        step(); idle();
        wr(9); ret(9);
        probe();
        chk("x9_ir_issue", issue, 1);
        step(); idle();
        probe();
        chk("x9_ir_cnt", dut.cnt_q[9], 1);
        wr(9);
        step(); idle();
        probe();
        chk("x9_cnt2", dut.cnt_q[9], 2);
        ret(9); kill_valid = 1; kill_dst = 9;
        step(); idle();
        probe();
        chk("x9_rk_cnt", dut.cnt_q[9], 0);
        chk("x9_rk_err", err, 0);
        wr(9);
        step(); idle();
        wr(9); ret(9); kill_valid = 1; kill_dst = 9;
        step(); idle();
        probe();
        chk("x9_all3_cnt", dut.cnt_q[9], 0);
        chk("x9_all3_err", err, 0);

        // freeze blocks increments only
        do_reset();
        wr(4);
        step(); idle();
        freeze = 1; wr(3); ret(4);
        probe();
        chk("frz_stall", stall, 0);
        chk("frz_issue", issue, 0);
        step(); idle();
        probe();
        chk("frz_cnt3", dut.cnt_q[3], 0);
        chk("frz_cnt4", dut.cnt_q[4], 0);
        chk("frz_busy", busy_vec, 0);

        // x0 retire and kill never underflow
        ret(0); kill_valid = 1; kill_dst = 0;
        step(); idle();
        probe();
        chk("x0_no_err", err, 0);

        // underflow is sticky
        ret(12);
        step(); idle();
        probe();
        chk("uf_cnt", dut.cnt_q[12], 0);
        chk("uf_err", err, 1);
        repeat (10) step();
        probe();
        chk("uf_sticky", err, 1);
        do_reset();
        probe();
        chk("uf_rst_err", err, 0);
        kill_valid = 1; kill_dst = 1;
        step(); idle();
        probe();
        chk("uf_kill_err", err, 1);

        // reset discards in-flight state
        do_reset();
        wr(6);
        step(); idle();
        do_reset();
        probe();
        chk("midrst_busy", busy_vec, 0);
        ret(6);
        step(); idle();
        probe();
        chk("midrst_err", err, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
